// File: rtl/weight_loader_pkg.sv
// Shared defaults, FSM state type and small helpers for the weight slice loader.
package weight_loader_pkg;

    localparam int unsigned DEF_DATA_WIDTH      = 16;
    localparam int unsigned DEF_KERNEL_SIZE_MAX = 3;
    localparam int unsigned DEF_WADDR_WIDTH     = 8;
    localparam int unsigned DEF_KS_WIDTH        = 4;
    localparam int unsigned SLICE_W =
        DEF_KERNEL_SIZE_MAX * DEF_KERNEL_SIZE_MAX * DEF_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, FIN} state_e;

    function automatic int unsigned lanes_used(input int unsigned ks);
        return ks * ks;
    endfunction

    function automatic logic ks_legal(input int unsigned ks, input int unsigned ksm);
        return (ks >= 1) && (ks <= ksm);
    endfunction

endpackage

// File: rtl/weight_slice_packer.sv
// Lane buffer for one kernel slice: element counter, per-slice clear and optional 180-degree
// flip (WEIGHT_LOADER_FLIP_EN). packed_word already includes the beat being accepted.
module weight_slice_packer
    import weight_loader_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter  int unsigned KERNEL_SIZE_MAX = DEF_KERNEL_SIZE_MAX,
    localparam int unsigned LANES           = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX,
    localparam int unsigned LEN_W           = $clog2(LANES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        beat,
    input  logic [LEN_W-1:0]            slice_len,
    input  logic [DATA_WIDTH-1:0]       data,
    output logic                        slice_full,
    output logic [LANES*DATA_WIDTH-1:0] packed_word
);

    logic [DATA_WIDTH-1:0] lanes_q [LANES];
    logic [DATA_WIDTH-1:0] lanes_d [LANES];
    logic [LEN_W-1:0]      elem_q;
    logic [LEN_W-1:0]      lane_idx;

    always_comb begin
`ifdef WEIGHT_LOADER_FLIP_EN
        lane_idx = slice_len - 1'b1 - elem_q;
`else
        lane_idx = elem_q;
`endif
        lanes_d = lanes_q;
        if (beat) begin
            lanes_d[lane_idx] = data;
        end
        slice_full  = beat && (elem_q == slice_len - 1'b1);
        packed_word = '0;
        for (int i = 0; i < LANES; i++) begin
            packed_word[i*DATA_WIDTH +: DATA_WIDTH] = lanes_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                lanes_q[i] <= '0;
            end
        end else if (clear || slice_full) begin
            // Completed or freshly started slice: unused lanes must read back as zero.
            elem_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            if (beat) begin
                elem_q <= elem_q + 1'b1;
            end
            for (int i = 0; i < LANES; i++) begin
                lanes_q[i] <= lanes_d[i];
            end
        end
    end

endmodule

// File: rtl/weight_slice_loader.sv
// Packs a float16 weight stream into ks*ks slices and writes one slice per cycle to the weight
// RAM from base_addr upward. Build option WEIGHT_LOADER_FLIP_EN stores slices rotated 180 degrees.
module weight_slice_loader
    import weight_loader_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter  int unsigned KERNEL_SIZE_MAX = DEF_KERNEL_SIZE_MAX,
    parameter  int unsigned WADDR_WIDTH     = DEF_WADDR_WIDTH,
    parameter  int unsigned KS_WIDTH        = DEF_KS_WIDTH,
    localparam int unsigned LANES           = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX,
    localparam int unsigned LEN_W           = $clog2(LANES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [KS_WIDTH-1:0]         kernel_size,
    input  logic [WADDR_WIDTH-1:0]      base_addr,
    input  logic [WADDR_WIDTH:0]        num_slices,
    input  logic                        s_valid,
    input  logic [DATA_WIDTH-1:0]       s_data,
    output logic                        s_ready,
    output logic                        ram_ena_w,
    output logic [WADDR_WIDTH-1:0]      ram_addr_write,
    output logic [LANES*DATA_WIDTH-1:0] ram_din,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    state_e                        state_q;
    logic [KS_WIDTH-1:0]           ks_q;
    logic [WADDR_WIDTH-1:0]        base_q;
    logic [WADDR_WIDTH:0]          n_q;
    logic [WADDR_WIDTH:0]          idx_q;
    logic                          ks_ok;
    logic                          clear;
    logic [LEN_W-1:0]              slice_len;
    logic                          slice_full;
    logic [LANES*DATA_WIDTH-1:0]   packed_word;

    assign ks_ok     = ks_legal(32'(kernel_size), KERNEL_SIZE_MAX);
    assign clear     = (state_q == IDLE) && start;
    assign slice_len = LEN_W'(lanes_used(32'(ks_q)));
    assign busy      = (state_q != IDLE);

    weight_slice_packer #(
        .DATA_WIDTH      (DATA_WIDTH),
        .KERNEL_SIZE_MAX (KERNEL_SIZE_MAX)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .beat        (s_valid && s_ready),
        .slice_len   (slice_len),
        .data        (s_data),
        .slice_full  (slice_full),
        .packed_word (packed_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ks_q           <= '0;
            base_q         <= '0;
            n_q            <= '0;
            idx_q          <= '0;
            s_ready        <= 1'b0;
            ram_ena_w      <= 1'b0;
            ram_addr_write <= '0;
            ram_din        <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            ram_ena_w <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ks_q   <= kernel_size;
                        base_q <= base_addr;
                        n_q    <= num_slices;
                        idx_q  <= '0;
                        if (num_slices == '0 || !ks_ok) begin
                            state_q <= FIN;
                            done    <= 1'b1;
                            err     <= !ks_ok;
                        end else begin
                            state_q <= FILL;
                            s_ready <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (slice_full) begin
                        state_q        <= WRITE;
                        s_ready        <= 1'b0;
                        ram_ena_w      <= 1'b1;
                        ram_addr_write <= base_q + idx_q[WADDR_WIDTH-1:0];
                        ram_din        <= packed_word;
                    end
                end
                WRITE: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q + 1'b1 == n_q) begin
                        state_q <= FIN;
                        done    <= 1'b1;
                    end else begin
                        state_q <= FILL;
                        s_ready <= 1'b1;
                    end
                end
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_slice_loader.sv
// Randomised self-checking bench for weight_slice_loader; expected RAM words come from a
// slice-level model of the packing rules (honours WEIGHT_LOADER_FLIP_EN like the DUT build).
module tb_weight_slice_loader;
    import weight_loader_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [3:0]         kernel_size = '0;
    logic [7:0]         base_addr = '0;
    logic [8:0]         num_slices = '0;
    logic               s_valid = 1'b0;
    logic [15:0]        s_data = '0;
    logic               s_ready;
    logic               ram_ena_w;
    logic [7:0]         ram_addr_write;
    logic [SLICE_W-1:0] ram_din;
    logic               busy;
    logic               done;
    logic               err;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [15:0]        stream[$];
    int                 beat_cyc[$];
    logic [7:0]         wr_addr[$];
    logic [SLICE_W-1:0] wr_data[$];
    int                 wr_cyc[$];

    weight_slice_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .kernel_size    (kernel_size),
        .base_addr      (base_addr),
        .num_slices     (num_slices),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .ram_ena_w      (ram_ena_w),
        .ram_addr_write (ram_addr_write),
        .ram_din        (ram_din),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && ram_ena_w) begin
            wr_addr.push_back(ram_addr_write);
            wr_data.push_back(ram_din);
            wr_cyc.push_back(cyc);
        end
    end

    // Slice s of the current stream as the RAM should hold it.
    function automatic logic [SLICE_W-1:0] model_word(input int ks, input int s);
        logic [SLICE_W-1:0] w;
        int kk;
        int lane;
        w  = '0;
        kk = ks * ks;
        for (int e = 0; e < kk; e++) begin
`ifdef WEIGHT_LOADER_FLIP_EN
            lane = kk - 1 - e;
`else
            lane = e;
`endif
            w[lane*16 +: 16] = stream[s*kk + e];
        end
        return w;
    endfunction

    task automatic fill_random(input int count);
        stream.delete();
        for (int i = 0; i < count; i++) stream.push_back(16'($urandom));
    endtask

    task automatic drive_load(input int ks, input int base, input int n, input int gap,
                              input bit chk_ready, input bit poke,
                              output bit got_done, output bit got_err,
                              output int start_cyc, output int done_cyc);
        int  idx;
        bit  acc;
        logic exp_r;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); beat_cyc.delete();
        got_done = 0; got_err = 0; done_cyc = -1; idx = 0;
        @(posedge clk); #1;
        start = 1'b1; kernel_size = 4'(ks); base_addr = 8'(base); num_slices = 9'(n);
        s_valid = 1'b0;
        start_cyc = cyc;
        for (int t = 0; t < 400 && !got_done; t++) begin
            @(negedge clk);
            if (chk_ready) begin
                exp_r = busy && !ram_ena_w && !done;
                n_cmp++;
                if (s_ready !== exp_r) begin
                    n_fail++;
                    $display("FAIL s_ready_in_write: got %b expected %b at cycle %0d",
                             s_ready, exp_r, cyc);
                end
            end
            if (done) begin got_done = 1; got_err = err; done_cyc = cyc; end
            acc = s_valid && s_ready;
            if (acc) beat_cyc.push_back(cyc);
            @(posedge clk); #1;
            start = poke && (t == 2);
            if (poke && t == 2) begin kernel_size = 4'd3; base_addr = 8'h40; num_slices = 9'd5; end
            if (acc) idx++;
            s_valid = (idx < stream.size()) && ($urandom_range(99) >= gap);
            s_data  = s_valid ? stream[idx] : 16'($urandom);
        end
        start = 1'b0; s_valid = 1'b0;
        n_cmp++;
        if (!got_done) begin
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done within 400 cycles");
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b expected 0", s_ready); end
        n_cmp++; if (ram_ena_w !== 1'b0) begin n_fail++; $display("FAIL rst_ena: got %b expected 0", ram_ena_w); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL rst_done_err: got %b expected 00", {done, err}); end
        n_cmp++; if (ram_addr_write !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %0h expected 0", ram_addr_write); end
        n_cmp++; if (ram_din !== '0) begin n_fail++; $display("FAIL rst_din: got %0h expected 0", ram_din); end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit gd, ge; int sc, dc;
        stream.delete();
        for (int i = 1; i <= 18; i++) stream.push_back(16'(i));
        drive_load(3, 5, 2, 0, 1'b0, 1'b0, gd, ge, sc, dc);
        n_cmp++; if (ge !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b expected 0", ge); end
        n_cmp++;
        if (wr_addr.size() != 2) begin
            n_fail++; $display("FAIL b2b_nwrites: got %0d expected 2", wr_addr.size());
        end else begin
            for (int s = 0; s < 2; s++) begin
                n_cmp++;
                if (wr_addr[s] !== 8'(5 + s)) begin n_fail++; $display("FAIL b2b_addr: got %0h expected %0h", wr_addr[s], 5 + s); end
                n_cmp++;
                if (wr_data[s] !== model_word(3, s)) begin n_fail++; $display("FAIL b2b_data: got %0h expected %0h", wr_data[s], model_word(3, s)); end
                n_cmp++;
                if (beat_cyc.size() < 9 * (s + 1) || wr_cyc[s] != beat_cyc[9*s + 8] + 1) begin
                    n_fail++; $display("FAIL b2b_write_latency: got write at cycle %0d, slice %0d", wr_cyc[s], s);
                end
            end
            n_cmp++;
            if (dc != wr_cyc[1] + 1) begin n_fail++; $display("FAIL b2b_done_latency: got %0d expected %0d", dc, wr_cyc[1] + 1); end
        end
    endtask

    task automatic test_small_kernel();
        bit gd, ge; int sc, dc;
        fill_random(4);
        drive_load(2, 9'h33, 1, 0, 1'b0, 1'b0, gd, ge, sc, dc);
        n_cmp++; if (ge !== 1'b0) begin n_fail++; $display("FAIL ks2_err: got %b expected 0", ge); end
        n_cmp++;
        if (wr_data.size() != 1) begin n_fail++; $display("FAIL ks2_nwrites: got %0d expected 1", wr_data.size()); end
        else if (wr_data[0] !== model_word(2, 0)) begin
            n_fail++; $display("FAIL ks2_data: got %0h expected %0h", wr_data[0], model_word(2, 0));
        end
    endtask

    task automatic test_gaps();
        bit gd, ge; int sc, dc;
        fill_random(27);
        drive_load(3, 100, 3, 50, 1'b1, 1'b0, gd, ge, sc, dc);
        n_cmp++;
        if (wr_data.size() != 3) begin n_fail++; $display("FAIL gaps_nwrites: got %0d expected 3", wr_data.size()); end
        else begin
            for (int s = 0; s < 3; s++) begin
                n_cmp++;
                if (wr_addr[s] !== 8'(100 + s) || wr_data[s] !== model_word(3, s)) begin
                    n_fail++; $display("FAIL gaps_slice: got %0h:%0h expected %0h:%0h", wr_addr[s], wr_data[s], 100 + s, model_word(3, s));
                end
            end
        end
    endtask

    task automatic test_degenerate();
        bit gd, ge; int sc, dc;
        stream.delete();
        drive_load(3, 20, 0, 0, 1'b0, 1'b0, gd, ge, sc, dc);
        n_cmp++; if (ge !== 1'b0 || wr_data.size() != 0) begin n_fail++; $display("FAIL n0: got err %b writes %0d expected 0 0", ge, wr_data.size()); end
        n_cmp++; if (gd && (dc - sc < 1 || dc - sc > 2)) begin n_fail++; $display("FAIL n0_latency: got %0d expected 1..2", dc - sc); end
        drive_load(0, 20, 1, 0, 1'b0, 1'b0, gd, ge, sc, dc);
        n_cmp++; if (ge !== 1'b1 || wr_data.size() != 0) begin n_fail++; $display("FAIL ks0: got err %b writes %0d expected 1 0", ge, wr_data.size()); end
        drive_load(4, 20, 2, 0, 1'b0, 1'b0, gd, ge, sc, dc);
        n_cmp++; if (ge !== 1'b1 || wr_data.size() != 0) begin n_fail++; $display("FAIL ks4: got err %b writes %0d expected 1 0", ge, wr_data.size()); end
        fill_random(4);
        drive_load(2, 10, 1, 0, 1'b0, 1'b1, gd, ge, sc, dc);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (wr_data.size() != 1 || wr_addr[0] !== 8'd10 || wr_data[0] !== model_word(2, 0)) begin
            n_fail++; $display("FAIL start_while_busy: got %0d writes expected 1 at addr a", wr_data.size());
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_while_busy_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_wrap();
        bit gd, ge; int sc, dc;
        fill_random(8);
        drive_load(2, 8'hFF, 2, 20, 1'b0, 1'b0, gd, ge, sc, dc);
        n_cmp++;
        if (wr_addr.size() != 2) begin n_fail++; $display("FAIL wrap_nwrites: got %0d expected 2", wr_addr.size()); end
        else begin
            n_cmp++; if (wr_addr[0] !== 8'hFF) begin n_fail++; $display("FAIL wrap_addr0: got %0h expected ff", wr_addr[0]); end
            n_cmp++; if (wr_addr[1] !== 8'h00) begin n_fail++; $display("FAIL wrap_addr1: got %0h expected 0", wr_addr[1]); end
            n_cmp++; if (wr_data[1] !== model_word(2, 1)) begin n_fail++; $display("FAIL wrap_data: got %0h expected %0h", wr_data[1], model_word(2, 1)); end
        end
    endtask

    task automatic test_reset_mid_load();
        bit gd, ge; int sc, dc; int beats;
        fill_random(9);
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        @(posedge clk); #1;
        start = 1'b1; kernel_size = 4'd3; base_addr = 8'h30; num_slices = 9'd1;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = stream[0]; beats = 0;
        for (int t = 0; t < 50 && beats < 4; t++) begin
            @(negedge clk);
            if (s_valid && s_ready) beats++;
            @(posedge clk); #1;
            s_valid = (beats < 4); s_data = stream[beats];
        end
        n_cmp++; if (beats != 4) begin n_fail++; $display("FAIL midrst_beats: got %0d expected 4", beats); end
        rst_n = 1'b0; s_valid = 1'b0;
        #1;
        n_cmp++;
        if ({busy, s_ready, ram_ena_w, done, err} !== 5'b0 || ram_addr_write !== 8'h00 || ram_din !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got %b/%0h/%0h expected zeros", {busy, s_ready, ram_ena_w, done, err}, ram_addr_write, ram_din);
        end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        n_cmp++; if (wr_data.size() != 0) begin n_fail++; $display("FAIL midrst_partial: got %0d writes expected 0", wr_data.size()); end
        fill_random(9);
        drive_load(3, 7, 1, 0, 1'b0, 1'b0, gd, ge, sc, dc);
        n_cmp++;
        if (wr_data.size() != 1 || wr_addr[0] !== 8'd7 || wr_data[0] !== model_word(3, 0)) begin
            n_fail++; $display("FAIL midrst_next_load: got %0d writes expected 1 correct slice", wr_data.size());
        end
    endtask

    task automatic test_random();
        bit gd, ge; int sc, dc; int ks, base, n;
        for (int it = 0; it < 5; it++) begin
            ks   = $urandom_range(3, 1);
            base = $urandom_range(255);
            n    = $urandom_range(3, 1);
            fill_random(ks * ks * n);
            drive_load(ks, base, n, $urandom_range(60), 1'b1, 1'b0, gd, ge, sc, dc);
            n_cmp++;
            if (wr_data.size() != n) begin n_fail++; $display("FAIL rand_nwrites: got %0d expected %0d", wr_data.size(), n); end
            else begin
                for (int s = 0; s < n; s++) begin
                    n_cmp++;
                    if (wr_addr[s] !== 8'(base + s) || wr_data[s] !== model_word(ks, s)) begin
                        n_fail++; $display("FAIL rand_slice: got %0h:%0h expected %0h:%0h", wr_addr[s], wr_data[s], 8'(base + s), model_word(ks, s));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_small_kernel();
        test_gaps();
        test_degenerate();
        test_wrap();
        test_reset_mid_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
